// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
//   Shared constants and types for the sequential MULTU/DIVU unit:
//   ALU control codes, operation encodings, FSM state encoding and widths.
package muldiv_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   Combinational datapath for one multiply/divide iteration. Chooses the
//   ALU operand and control from the working registers, then forms the next
//   working-register values from the shared ALU's sum and carry.
// Ports:
//   op        in   0 = MULTU (shift-add), 1 = DIVU (restoring)
//   w_hi      in   working high word (partial product / partial remainder)
//   w_lo      in   working low word (multiplier bits / dividend->quotient)
//   alu_sum   in   shared ALU sum for the operands driven this cycle
//   alu_cout  in   shared ALU carry out
//   nxt_hi    out  next working high word
//   nxt_lo    out  next working low word
//   alu_a     out  ALU operand A (operand B is the held D register)
//   alu_ctrl  out  ALU control (add for MULTU, subtract for DIVU)
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic             op,
    input  logic [WIDTH-1:0] w_hi,
    input  logic [WIDTH-1:0] w_lo,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [2:0]       alu_ctrl
);

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    logic [WIDTH-1:0] trial;
    assign trial = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        nxt_hi   = w_hi;
        nxt_lo   = w_lo;
        alu_a    = w_hi;
        alu_ctrl = ALU_ADD;

        if (op == OP_MULTU) begin
            alu_a    = w_hi;
            alu_ctrl = ALU_ADD;
            // The carry out becomes bit 63 of the shifted partial product.
            if (w_lo[0]) begin
                {nxt_hi, nxt_lo} = {alu_cout, alu_sum, w_lo[WIDTH-1:1]};
            end else begin
                {nxt_hi, nxt_lo} = {1'b0, w_hi, w_lo[WIDTH-1:1]};
            end
        end else begin
            alu_a    = trial;
            alu_ctrl = ALU_SUB;
            // w_hi[31] set means the shifted remainder has a 33rd bit, so it
            // is certainly >= the divisor even when the 32-bit compare says no.
            if (w_hi[WIDTH-1] | alu_cout) begin
                nxt_hi = alu_sum;
                nxt_lo = {w_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = trial;
                nxt_lo = {w_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Multi-cycle unsigned 32x32 multiply (MULTU) and divide (DIVU) sequencer
//   that borrows the pipeline's 32-bit ALU for one add/subtract per cycle.
//   32 iterations, then a one-cycle DONE state where hi/lo become valid.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, accepted only in IDLE
//   op        in   0 = MULTU, 1 = DIVU (sampled with start)
//   src_a     in   multiplicand / dividend (sampled with start)
//   src_b     in   multiplier / divisor (sampled with start)
//   flush     in   cancels an in-flight operation
//   busy      out  high in ITER and DONE
//   done      out  one-cycle pulse, hi/lo valid from this cycle
//   hi        out  product[63:32] / remainder
//   lo        out  product[31:0] / quotient
//   alu_a     out  shared ALU operand A
//   alu_b     out  shared ALU operand B
//   alu_ctrl  out  shared ALU control
//   alu_sum   in   shared ALU sum
//   alu_cout  in   shared ALU carry out
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = muldiv_seq_pkg::WIDTH,
    parameter int CNT_W = muldiv_seq_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] w_hi, w_lo, d;
    logic             op_q;

    // Operands of the last ITER cycle, presented to the ALU while idle/done.
    logic [WIDTH-1:0] alu_a_hold, alu_b_hold;

    logic [WIDTH-1:0] step_hi, step_lo, step_a;
    logic [2:0]       step_ctrl;

    logic             accept;
    assign accept = (state == S_IDLE) && start && !flush;

    muldiv_step u_step (
        .op       (op_q),
        .w_hi     (w_hi),
        .w_lo     (w_lo),
        .alu_sum  (alu_sum),
        .alu_cout (alu_cout),
        .nxt_hi   (step_hi),
        .nxt_lo   (step_lo),
        .alu_a    (step_a),
        .alu_ctrl (step_ctrl)
    );

    // ALU drive depends only on registered state, never on this cycle's inputs.
    always_comb begin
        if (state == S_ITER) begin
            alu_a    = step_a;
            alu_b    = d;
            alu_ctrl = step_ctrl;
        end else begin
            alu_a    = alu_a_hold;
            alu_b    = alu_b_hold;
            alu_ctrl = ALU_ADD;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) next_state = S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (flush)                 next_state = S_IDLE;
                else if (cnt == CNT_LAST)  next_state = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            w_hi       <= '0;
            w_lo       <= '0;
            d          <= '0;
            op_q       <= OP_MULTU;
            hi         <= '0;
            lo         <= '0;
            alu_a_hold <= '0;
            alu_b_hold <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
            if (accept) begin
                w_hi <= '0;
                w_lo <= (op == OP_DIVU) ? src_a : src_b;
                d    <= (op == OP_DIVU) ? src_b : src_a;
                op_q <= op;
                cnt  <= '0;
            end
            if (state == S_ITER) begin
                w_hi       <= step_hi;
                w_lo       <= step_lo;
                cnt        <= cnt + CNT_W'(1);
                alu_a_hold <= step_a;
                alu_b_hold <= d;
                // Result registers load with the final iteration so they are
                // already valid in the DONE cycle; a flush leaves them alone.
                if (cnt == CNT_LAST && !flush) begin
                    hi <= step_hi;
                    lo <= step_lo;
                end
            end
        end
    end

endmodule
